// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state encoding, digit-select and BCD limit constants for stopwatch_ctrl.
package stopwatch_ctrl_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [3:0] SW_IDLE  = 4'd0;
    localparam logic [3:0] SW_RUN   = 4'd1;
    localparam logic [3:0] SW_PAUSE = 4'd2;
    localparam logic [3:0] TM_IDLE  = 4'd3;
    localparam logic [3:0] TM_EDIT  = 4'd4;
    localparam logic [3:0] TM_RUN   = 4'd5;
    localparam logic [3:0] TM_PAUSE = 4'd6;
    localparam logic [3:0] TM_ALARM = 4'd7;
    localparam logic [3:0] LOAD     = 4'd8;

    localparam logic [1:0] DIG_MIN_TENS = 2'd3;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_SEC_ONES = 2'd0;

    localparam bcd_t ONES_MAX = 4'd9;
    localparam bcd_t TENS_MAX = 4'd5;

    function automatic bcd_t bcd_inc(input bcd_t d, input bcd_t lim);
        return (d >= lim) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector. The history flop resets high so a button
// held through reset never produces an edge.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn;
        end
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button-driven control sequencer for stopwatch_timer: mode/start/load, preset editing, alarm.
// Optional lap display freeze is enabled by defining STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned ALARM_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       done_in,
    input  logic [3:0] cnt_min_tens,
    input  logic [3:0] cnt_min_ones,
    input  logic [3:0] cnt_sec_tens,
    input  logic [3:0] cnt_sec_ones,
    output logic       tmr_mode,
    output logic       tmr_start,
    output logic       tmr_load,
    output logic [3:0] ld_min_tens,
    output logic [3:0] ld_min_ones,
    output logic [3:0] ld_sec_tens,
    output logic [3:0] ld_sec_ones,
    output logic [3:0] disp_min_tens,
    output logic [3:0] disp_min_ones,
    output logic [3:0] disp_sec_tens,
    output logic [3:0] disp_sec_ones,
    output logic       editing,
    output logic [1:0] edit_digit,
    output logic       alarm,
    output logic [3:0] state_dbg
);

    localparam int unsigned ALARM_CYCLES = CLK_FREQ * ALARM_SEC;
    localparam int unsigned ACNT_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [ACNT_W-1:0] ALARM_LAST = ACNT_W'(ALARM_CYCLES - 1);

    logic [4:0] btn_vec;
    logic [4:0] rise_vec;
    logic       e_start, e_clear, e_mode, e_set, e_inc;

    assign btn_vec = {btn_inc, btn_set, btn_mode, btn_clear, btn_start};

    for (genvar i = 0; i < 5; i++) begin : g_edge
        btn_edge u_edge (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_vec[i]),
            .rise (rise_vec[i])
        );
    end

    assign e_start = rise_vec[0];
    assign e_clear = rise_vec[1];
    assign e_mode  = rise_vec[2];
    assign e_set   = rise_vec[3];
    assign e_inc   = rise_vec[4];

    logic [3:0]        state_q, state_d;
    logic [3:0]        ret_q, ret_d;
    logic [3:0][3:0]   ld_src_q, ld_src_d;
    logic [3:0][3:0]   preset_q, preset_d;
    logic [1:0]        edit_digit_q, edit_digit_d;
    logic [ACNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic              go_load, load_preset;
    logic [3:0]        load_ret;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic              lap_toggle;
`endif

    // Each branch tests only the events that state acts on, in priority order.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        ld_src_d     = ld_src_q;
        preset_d     = preset_q;
        edit_digit_d = edit_digit_q;
        alarm_cnt_d  = alarm_cnt_q;
        go_load      = 1'b0;
        load_preset  = 1'b0;
        load_ret     = SW_IDLE;
`ifdef STOPWATCH_CTRL_LAP_EN
        lap_toggle   = 1'b0;
`endif
        case (state_q)
            SW_IDLE, SW_PAUSE: begin
                if (e_start) begin
                    state_d = SW_RUN;
                end else if (e_clear) begin
                    go_load = 1'b1;
                end else if (e_mode) begin
                    go_load     = 1'b1;
                    load_preset = 1'b1;
                    load_ret    = TM_IDLE;
                end
            end
            SW_RUN: begin
                if (e_start) begin
                    state_d = SW_PAUSE;
`ifdef STOPWATCH_CTRL_LAP_EN
                end else if (e_clear) begin
                    lap_toggle = 1'b1;
`endif
                end
            end
            TM_IDLE: begin
                if (e_start && (|preset_q)) begin
                    go_load     = 1'b1;
                    load_preset = 1'b1;
                    load_ret    = TM_RUN;
                end else if (e_mode) begin
                    go_load = 1'b1;
                end else if (e_set) begin
                    state_d      = TM_EDIT;
                    edit_digit_d = DIG_MIN_TENS;
                end
            end
            TM_EDIT: begin
                if (e_set) begin
                    if (edit_digit_q == DIG_SEC_ONES) begin
                        state_d = TM_IDLE;
                    end else begin
                        edit_digit_d = edit_digit_q - 2'd1;
                    end
                end else if (e_inc) begin
                    // Odd digit indices are the tens positions.
                    preset_d[edit_digit_q] = bcd_inc(preset_q[edit_digit_q],
                                                     edit_digit_q[0] ? TENS_MAX : ONES_MAX);
                end
            end
            TM_RUN: begin
                if (done_in) begin
                    state_d     = TM_ALARM;
                    alarm_cnt_d = '0;
                end else if (e_start) begin
                    state_d = TM_PAUSE;
                end
            end
            TM_PAUSE: begin
                if (e_start) begin
                    state_d = TM_RUN;
                end else if (e_clear) begin
                    go_load     = 1'b1;
                    load_preset = 1'b1;
                    load_ret    = TM_IDLE;
                end else if (e_mode) begin
                    go_load = 1'b1;
                end
            end
            TM_ALARM: begin
                if (e_start || e_clear || (alarm_cnt_q == ALARM_LAST)) begin
                    go_load     = 1'b1;
                    load_preset = 1'b1;
                    load_ret    = TM_IDLE;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + ACNT_W'(1);
                end
            end
            LOAD: begin
                state_d = ret_q;
            end
            default: begin
                state_d = SW_IDLE;
            end
        endcase

        if (go_load) begin
            state_d  = LOAD;
            ret_d    = load_ret;
            ld_src_d = load_preset ? preset_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SW_IDLE;
            ret_q        <= SW_IDLE;
            ld_src_q     <= '0;
            preset_q     <= '0;
            edit_digit_q <= DIG_SEC_ONES;
            alarm_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            ld_src_q     <= ld_src_d;
            preset_q     <= preset_d;
            edit_digit_q <= edit_digit_d;
            alarm_cnt_q  <= alarm_cnt_d;
        end
    end

    always_comb begin
        tmr_mode  = 1'b1;
        tmr_start = 1'b0;
        tmr_load  = 1'b0;
        editing   = 1'b0;
        alarm     = 1'b0;
        case (state_q)
            SW_IDLE, SW_PAUSE: tmr_mode = 1'b0;
            SW_RUN: begin
                tmr_mode  = 1'b0;
                tmr_start = 1'b1;
            end
            TM_RUN:   tmr_start = 1'b1;
            TM_EDIT:  editing   = 1'b1;
            TM_ALARM: alarm     = 1'b1;
            LOAD:     tmr_load  = 1'b1;
            default:  ;
        endcase
    end

    logic [3:0][3:0] cnt_digits;
    logic [3:0][3:0] disp_digits;

    assign cnt_digits = {cnt_min_tens, cnt_min_ones, cnt_sec_tens, cnt_sec_ones};

`ifdef STOPWATCH_CTRL_LAP_EN
    logic            lap_hold_q;
    logic [3:0][3:0] lap_snap_q;

    // Snapshot on the 0->1 toggle; any load drops the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_hold_q <= 1'b0;
            lap_snap_q <= '0;
        end else if (go_load) begin
            lap_hold_q <= 1'b0;
        end else if (lap_toggle) begin
            lap_hold_q <= ~lap_hold_q;
            if (!lap_hold_q) begin
                lap_snap_q <= cnt_digits;
            end
        end
    end

    assign disp_digits = lap_hold_q ? lap_snap_q : cnt_digits;
`else
    assign disp_digits = cnt_digits;
`endif

    assign ld_min_tens   = ld_src_q[3];
    assign ld_min_ones   = ld_src_q[2];
    assign ld_sec_tens   = ld_src_q[1];
    assign ld_sec_ones   = ld_src_q[0];
    assign disp_min_tens = disp_digits[3];
    assign disp_min_ones = disp_digits[2];
    assign disp_sec_tens = disp_digits[1];
    assign disp_sec_ones = disp_digits[0];
    assign edit_digit    = edit_digit_q;
    assign state_dbg     = state_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the `stopwatch_timer` counter block. It turns five debounced front-panel buttons into the counter's `mode`, `start` and `load` controls. It also owns the timer preset, editing it one digit at a time, and raises and times out the alarm when the countdown finishes. It sits between the button debouncers and `stopwatch_timer`, with its load and control outputs wired straight to that block.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, clock cycles per second; sets the alarm timeout base.
- ALARM_SEC, 10, alarm auto-clear timeout in seconds.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_mode, btn_start, btn_clear, btn_set, btn_inc  in  1 each  debounced levels, synchronous to clk.
- done_in  in  1  `done` from the counter.
- cnt_min_tens, cnt_min_ones, cnt_sec_tens, cnt_sec_ones  in  4 each  live counter digits.
- tmr_mode  out  1  to counter `mode` (0 = stopwatch, 1 = timer).
- tmr_start  out  1  to counter `start`.
- tmr_load  out  1  to counter `load`.
- ld_min_tens, ld_min_ones, ld_sec_tens, ld_sec_ones  out  4 each  to counter load digits.
- disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones  out  4 each  digits to the display.
- editing  out  1  high in TM_EDIT.
- edit_digit  out  2  digit selected for editing: 3 = min_tens, 2 = min_ones, 1 = sec_tens, 0 = sec_ones.
- alarm  out  1  high in TM_ALARM.
- state_dbg  out  4  current state encoding.

## Operation
Button edges:
- Each button's edge is `btn & ~btn_q`.
- `btn_q` resets to 1, so a button held through reset produces no edge.
- Per cycle, only the highest-priority applicable event is acted on; all others are dropped. Priority: done_in > start > clear > mode > set > inc.

States: SW_IDLE, SW_RUN, SW_PAUSE, TM_IDLE, TM_EDIT, TM_RUN, TM_PAUSE, TM_ALARM, LOAD.

Output decode:
- tmr_mode = 0 in SW_*, 1 in TM_* and LOAD.
- tmr_start = 1 only in SW_RUN and TM_RUN.
- tmr_load = 1 only in LOAD.
- ld_* = the `ld_src` register, which holds either the preset or all zeros.
- LOAD is a one-cycle state; it always proceeds to the state held in the `ret` register.

Transitions:
- SW_IDLE:
  - start → SW_RUN.
  - clear → LOAD(zeros, ret SW_IDLE).
  - mode → LOAD(preset, ret TM_IDLE).
- SW_RUN: start → SW_PAUSE.
- SW_PAUSE:
  - start → SW_RUN.
  - clear → LOAD(zeros, ret SW_IDLE).
  - mode → LOAD(preset, ret TM_IDLE).
- TM_IDLE:
  - start → if preset is nonzero, LOAD(preset, ret TM_RUN); if preset = 00:00, ignore.
  - set → TM_EDIT with edit_digit = 3.
  - mode → LOAD(zeros, ret SW_IDLE).
- TM_EDIT:
  - inc → selected preset digit +1; ones digits wrap 9→0, tens digits wrap 5→0.
  - set → edit_digit − 1; from digit 0, set → TM_IDLE.
  - All other buttons are ignored.
- TM_RUN:
  - done_in → TM_ALARM. done_in wins over start in the same cycle.
  - start → TM_PAUSE.
- TM_PAUSE:
  - start → TM_RUN.
  - clear → LOAD(preset, ret TM_IDLE).
  - mode → LOAD(zeros, ret SW_IDLE).
- TM_ALARM:
  - start, clear, or the timeout counter reaching CLK_FREQ*ALARM_SEC−1 → LOAD(preset, ret TM_IDLE).
  - The timeout counter is zeroed on entry to TM_ALARM.

Preset:
- Four BCD registers; reset value 00:00.
- Retained across mode switches. Only TM_EDIT modifies them.

## Timing
Reset:
- state = SW_IDLE.
- All outputs = 0; disp_* = cnt_* as defined below.
- preset = 0, ld_src = 0, ret = SW_IDLE, edit_digit = 0.

Latency:
- A button rising before clock edge k is acted on at edge k. Outputs reflect the new state after edge k.
- Any load sequence costs exactly one extra cycle for LOAD before the target state.
- done_in is sampled level-wise and only in TM_RUN.

Boundaries:
- Reset asserted mid-LOAD or mid-alarm aborts to reset values on the next edge.
- The alarm timeout counter is at least $clog2(CLK_FREQ*ALARM_SEC) bits.

## Configuration
STOPWATCH_CTRL_LAP_EN defined:
- A clear edge in SW_RUN toggles `lap_hold`.
- Entering lap_hold = 1 snapshots cnt_* into disp_*; the display stays frozen while the counter keeps running.
- lap_hold = 0 passes cnt_* straight to disp_*.
- lap_hold is cleared in LOAD and by reset; SW_PAUSE keeps its value.

STOPWATCH_CTRL_LAP_EN undefined:
- disp_* = cnt_* combinationally.
- Clear is ignored in SW_RUN.

## Structure
- Package `stopwatch_ctrl_pkg` holds:
  - the state encoding constants;
  - the digit-select constants DIG_MIN_TENS..DIG_SEC_ONES;
  - BCD limits ONES_MAX = 9 and TENS_MAX = 5.
- Sub-module `btn_edge`: one registered rising-edge detector with reset-to-1, instantiated five times.

## Test plan
- Stopwatch cycle (CLK_FREQ = 10): reset, pulse start → tmr_mode = 0, tmr_start = 1 the next cycle; pulse start → SW_PAUSE; pulse clear → exactly one cycle of tmr_load = 1, tmr_mode = 1, ld = 00:00, then SW_IDLE.
- Preset edit: mode, set, inc×2 (min_tens = 2), set, inc×10 (min_ones wraps back to 0), set, set, inc×6 (sec_ones = 6), set → TM_IDLE with preset 20:06.
- Timer run: preset 00:03, start → LOAD with ld = 00:03 then TM_RUN; done_in = 1 → alarm = 1, tmr_start = 0; after CLK_FREQ*ALARM_SEC cycles → LOAD(00:03) → TM_IDLE, alarm = 0.
- Priority: in TM_RUN, assert done_in and a start edge in the same cycle → TM_ALARM, not TM_PAUSE. Preset 00:00 plus start in TM_IDLE → no LOAD.
- Reset robustness: hold btn_start through reset release → no transition. Assert rst during TM_ALARM → SW_IDLE with all outputs 0.
- Lap (with the macro): SW_RUN, cnt = 01:23, clear → disp frozen at 01:23 while cnt advances; clear again → disp tracks cnt.
